// File: rtl/ff_compare_if.sv
// Bus between the tester controller and the ff_compare response checker.
interface ff_compare_if #(
   parameter int unsigned CW  = 8,
   parameter int unsigned FCW = 16,
   parameter int unsigned VCW = 16
);
   logic           EN;
   logic [CW-1:0]  CYCLE_LENGTH;
   logic [CW-1:0]  STROBE_START;
   logic [CW-1:0]  STROBE_END;
   logic           CMP_MODE;
   logic           PIN;
   logic           EXP;
   logic           MASK;
   logic           CLR_RESULTS;
   logic           CYCLE_DONE;
   logic           CYCLE_FAIL;
   logic           FAIL_STICKY;
   logic [FCW-1:0] FAIL_COUNT;
   logic [VCW-1:0] VEC_COUNT;
   logic [VCW-1:0] FIRST_FAIL_VEC;

   modport master (
      output EN, CYCLE_LENGTH, STROBE_START, STROBE_END, CMP_MODE,
             PIN, EXP, MASK, CLR_RESULTS,
      input  CYCLE_DONE, CYCLE_FAIL, FAIL_STICKY, FAIL_COUNT,
             VEC_COUNT, FIRST_FAIL_VEC
   );

   modport slave (
      input  EN, CYCLE_LENGTH, STROBE_START, STROBE_END, CMP_MODE,
             PIN, EXP, MASK, CLR_RESULTS,
      output CYCLE_DONE, CYCLE_FAIL, FAIL_STICKY, FAIL_COUNT,
             VEC_COUNT, FIRST_FAIL_VEC
   );
endinterface

// File: rtl/ff_compare.sv
// Per-tester-cycle pin compare with edge/window strobe and sticky result counters.
module ff_compare #(
   parameter int unsigned CW  = 8,
   parameter int unsigned FCW = 16,
   parameter int unsigned VCW = 16
) (
   input  logic         CLK,
   input  logic         RST,
   ff_compare_if.slave  bus
);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   logic           sync1_q, pin_s_q;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           exp_l_q, exp_l_d;
   logic           mask_l_q, mask_l_d;
   logic           mis_q, mis_d;
   logic           done_q, done_d;
   logic           fail_q, fail_d;
   logic           sticky_q, sticky_d;
   logic [FCW-1:0] fcnt_q, fcnt_d;
   logic [VCW-1:0] vcnt_q, vcnt_d;
   logic [VCW-1:0] ffv_q, ffv_d;

   logic [CW-1:0]  len_eff, end_eff;
   logic           first, last, exp_eff, mask_eff, in_win, hit, mis_acc;

   // Strobe decode; at counter 1 the incoming EXP/MASK apply since they latch on that edge.
   always_comb begin
      len_eff  = (bus.CYCLE_LENGTH == '0) ? CNT_ONE : bus.CYCLE_LENGTH;
      end_eff  = (bus.STROBE_END < bus.STROBE_START) ? bus.STROBE_START : bus.STROBE_END;
      first    = (cnt_q == CNT_ONE);
      last     = (cnt_q == len_eff);
      exp_eff  = first ? bus.EXP  : exp_l_q;
      mask_eff = first ? bus.MASK : mask_l_q;
      in_win   = bus.CMP_MODE ? ((cnt_q >= bus.STROBE_START) && (cnt_q <= end_eff))
                              : (cnt_q == bus.STROBE_START);
      hit      = in_win && (bus.STROBE_START <= len_eff) && (pin_s_q != exp_eff);
   end

   // Next state: cycle sequencing, mismatch accumulation, result accumulators.
   always_comb begin
      cnt_d    = cnt_q;
      exp_l_d  = exp_l_q;
      mask_l_d = mask_l_q;
      mis_d    = mis_q;
      done_d   = 1'b0;
      fail_d   = 1'b0;
      sticky_d = sticky_q;
      fcnt_d   = fcnt_q;
      vcnt_d   = vcnt_q;
      ffv_d    = ffv_q;
      mis_acc  = 1'b0;

      if (!bus.EN) begin
         cnt_d = CNT_ONE;
         mis_d = 1'b0;
      end else begin
         if (first) begin
            exp_l_d  = bus.EXP;
            mask_l_d = bus.MASK;
         end
         mis_acc = (first ? 1'b0 : mis_q) | hit;
         if (last) begin
            cnt_d  = CNT_ONE;
            mis_d  = 1'b0;
            done_d = 1'b1;
            fail_d = mis_acc & ~mask_eff;
            if (vcnt_q != '1) vcnt_d = vcnt_q + VCW'(1);
            if (fail_d) begin
               if (fcnt_q != '1) fcnt_d = fcnt_q + FCW'(1);
               if (!sticky_q) begin
                  ffv_d    = vcnt_q;
                  sticky_d = 1'b1;
               end
            end
         end else begin
            cnt_d = cnt_q + CW'(1);
            mis_d = mis_acc;
         end
      end

      if (bus.CLR_RESULTS) begin
         sticky_d = 1'b0;
         fcnt_d   = '0;
         vcnt_d   = '0;
         ffv_d    = '0;
      end
   end

   // State registers with synchronous active-high reset, including the pin synchronizer.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q  <= 1'b0;
         pin_s_q  <= 1'b0;
         cnt_q    <= CNT_ONE;
         exp_l_q  <= 1'b0;
         mask_l_q <= 1'b0;
         mis_q    <= 1'b0;
         done_q   <= 1'b0;
         fail_q   <= 1'b0;
         sticky_q <= 1'b0;
         fcnt_q   <= '0;
         vcnt_q   <= '0;
         ffv_q    <= '0;
      end else begin
         sync1_q  <= bus.PIN;
         pin_s_q  <= sync1_q;
         cnt_q    <= cnt_d;
         exp_l_q  <= exp_l_d;
         mask_l_q <= mask_l_d;
         mis_q    <= mis_d;
         done_q   <= done_d;
         fail_q   <= fail_d;
         sticky_q <= sticky_d;
         fcnt_q   <= fcnt_d;
         vcnt_q   <= vcnt_d;
         ffv_q    <= ffv_d;
      end
   end

   assign bus.CYCLE_DONE     = done_q;
   assign bus.CYCLE_FAIL     = fail_q;
   assign bus.FAIL_STICKY    = sticky_q;
   assign bus.FAIL_COUNT     = fcnt_q;
   assign bus.VEC_COUNT      = vcnt_q;
   assign bus.FIRST_FAIL_VEC = ffv_q;
endmodule

// File: tb/tb_ff_compare.sv
// Directed plus randomized bench for ff_compare with a per-cycle sample-set reference model.
module tb_ff_compare;
   localparam int unsigned CW  = 8;
   localparam int unsigned FCW = 4;
   localparam int unsigned VCW = 16;
   localparam int FMAX = (1 << FCW) - 1;
   localparam int VMAX = (1 << VCW) - 1;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   ff_compare_if #(.CW(CW), .FCW(FCW), .VCW(VCW)) bus ();
   ff_compare #(.CW(CW), .FCW(FCW), .VCW(VCW)) dut (.CLK(CLK), .RST(RST), .bus(bus));

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;
   int edge_n   = 0;
   int done_seen = 0;
   int last_done_edge = 0;
   int done_gap = 0;

   // reference model state
   int m_cnt = 1;
   bit m_s1, m_s2, m_exp, m_mask;
   bit samp [0:255];
   bit e_done, e_fail, e_sticky;
   int e_fcnt, e_vcnt, e_ffv;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Model one CLK edge: pin_s lags PIN by two edges; a cycle's result is judged
   // from the full set of pin_s samples it collected, per counter value.
   task automatic model_edge();
      bit ps;
      bit f;
      int len, lo, hi, old_v;
      ps = m_s2;
      if (RST) begin
         m_cnt = 1; m_s1 = 0; m_s2 = 0; m_exp = 0; m_mask = 0;
         e_done = 0; e_fail = 0; e_sticky = 0; e_fcnt = 0; e_vcnt = 0; e_ffv = 0;
         return;
      end
      m_s2 = m_s1;
      m_s1 = bus.PIN;
      e_done = 0;
      e_fail = 0;
      if (!bus.EN) begin
         m_cnt = 1;
      end else begin
         len = (bus.CYCLE_LENGTH == 0) ? 1 : int'(bus.CYCLE_LENGTH);
         if (m_cnt == 1) begin
            m_exp  = bus.EXP;
            m_mask = bus.MASK;
         end
         samp[m_cnt] = ps;
         if (m_cnt == len) begin
            lo = int'(bus.STROBE_START);
            hi = (bus.CMP_MODE && bus.STROBE_END > bus.STROBE_START) ? int'(bus.STROBE_END) : lo;
            f = 0;
            for (int k = lo; k <= hi; k++)
               if (k >= 1 && k <= len && samp[k] != m_exp) f = 1;
            e_done = 1;
            e_fail = f & !m_mask;
            old_v = e_vcnt;
            if (e_vcnt < VMAX) e_vcnt++;
            if (e_fail) begin
               if (e_fcnt < FMAX) e_fcnt++;
               if (!e_sticky) begin
                  e_ffv = old_v;
                  e_sticky = 1;
               end
            end
            m_cnt = 1;
         end else begin
            m_cnt++;
         end
      end
      if (bus.CLR_RESULTS) begin
         e_sticky = 0; e_fcnt = 0; e_vcnt = 0; e_ffv = 0;
      end
   endtask

   // One CLK: model the edge, then compare every output 1 time unit later.
   task automatic tick();
      @(posedge CLK);
      edge_n++;
      model_edge();
      #1;
      check("done",   32'(bus.CYCLE_DONE),     32'(e_done));
      check("fail",   32'(bus.CYCLE_FAIL),     32'(e_fail));
      check("sticky", 32'(bus.FAIL_STICKY),    32'(e_sticky));
      check("fcnt",   32'(bus.FAIL_COUNT),     32'(e_fcnt));
      check("vcnt",   32'(bus.VEC_COUNT),      32'(e_vcnt));
      check("ffv",    32'(bus.FIRST_FAIL_VEC), 32'(e_ffv));
      if (bus.CYCLE_DONE === 1'b1) begin
         done_seen++;
         done_gap = edge_n - last_done_edge;
         last_done_edge = edge_n;
      end
   endtask

   task automatic set_cfg(input int len, input int st, input int en_, input bit mode,
                          input bit ex, input bit mk);
      bus.CYCLE_LENGTH = CW'(len);
      bus.STROBE_START = CW'(st);
      bus.STROBE_END   = CW'(en_);
      bus.CMP_MODE     = mode;
      bus.EXP          = ex;
      bus.MASK         = mk;
   endtask

   initial begin
      bus.EN = 0; bus.PIN = 0; bus.CLR_RESULTS = 0;
      set_cfg(0, 0, 0, 0, 0, 0);

      // reset state
      RST = 1;
      repeat (3) tick();
      check("rst_vcnt", 32'(bus.VEC_COUNT), 32'd0);
      check("rst_done", 32'(bus.CYCLE_DONE), 32'd0);
      RST = 0;

      // edge strobe: three passing cycles then one failing
      set_cfg(10, 5, 0, 0, 1, 0);
      bus.PIN = 1; bus.EN = 1;
      done_seen = 0;
      repeat (30) tick();
      bus.PIN = 0;
      repeat (10) tick();
      check("edge_dones", 32'(done_seen), 32'd4);
      check("edge_gap",   32'(done_gap), 32'd10);
      check("edge_fail",  32'(bus.CYCLE_FAIL), 32'd1);
      check("edge_fcnt",  32'(bus.FAIL_COUNT), 32'd1);
      check("edge_ffv",   32'(bus.FIRST_FAIL_VEC), 32'd3);
      check("edge_vcnt",  32'(bus.VEC_COUNT), 32'd4);
      check("edge_stky",  32'(bus.FAIL_STICKY), 32'd1);

      // window glitch inside (pin_s at 9) then outside (pin_s at 14)
      set_cfg(20, 6, 12, 1, 0, 0);
      for (int i = 0; i < 20; i++) begin
         bus.PIN = (m_cnt == 7);
         tick();
      end
      check("win_in_done", 32'(bus.CYCLE_DONE), 32'd1);
      check("win_in_fail", 32'(bus.CYCLE_FAIL), 32'd1);
      for (int i = 0; i < 20; i++) begin
         bus.PIN = (m_cnt == 12);
         tick();
      end
      check("win_out_done", 32'(bus.CYCLE_DONE), 32'd1);
      check("win_out_fail", 32'(bus.CYCLE_FAIL), 32'd0);

      // masked failing edge compare
      set_cfg(10, 5, 0, 0, 1, 1);
      bus.PIN = 0;
      repeat (10) tick();
      check("mask_fail", 32'(bus.CYCLE_FAIL), 32'd0);
      check("mask_vcnt", 32'(bus.VEC_COUNT), 32'd7);
      check("mask_fcnt", 32'(bus.FAIL_COUNT), 32'd2);
      bus.MASK = 0;

      // strobe beyond cycle end never fails
      set_cfg(10, 15, 0, 0, 0, 0);
      for (int c = 0; c < 3; c++) begin
         bus.EXP = 1'($urandom);
         for (int i = 0; i < 10; i++) begin
            bus.PIN = 1'($urandom);
            tick();
         end
         check("late_done", 32'(bus.CYCLE_DONE), 32'd1);
         check("late_fail", 32'(bus.CYCLE_FAIL), 32'd0);
      end
      check("late_vcnt", 32'(bus.VEC_COUNT), 32'd10);

      // CYCLE_LENGTH 0 behaves as 1: a result every CLK
      set_cfg(0, 1, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) begin
         bus.PIN = 1'($urandom);
         tick();
         check("len0_done", 32'(bus.CYCLE_DONE), 32'd1);
      end

      // FAIL_COUNT saturation at 4 bits
      bus.PIN = 0;
      repeat (20) tick();
      check("sat_fcnt", 32'(bus.FAIL_COUNT), 32'd15);

      // randomized configurations, changed only at cycle boundaries
      for (int i = 0; i < 1500; i++) begin
         if (m_cnt == 1)
            set_cfg(int'($urandom_range(0, 12)), int'($urandom_range(0, 14)),
                    int'($urandom_range(0, 14)), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 3) == 0));
         bus.PIN = 1'($urandom);
         bus.CLR_RESULTS = ($urandom_range(0, 39) == 0);
         tick();
      end
      bus.CLR_RESULTS = 0;

      // realign to a cycle start
      for (int i = 0; i < 16 && m_cnt != 1; i++) tick();
      check("align", 32'(m_cnt), 32'd1);

      // clear collides with a failing CYCLE_DONE
      set_cfg(10, 5, 0, 0, 1, 0);
      bus.PIN = 0;
      repeat (9) tick();
      bus.CLR_RESULTS = 1;
      tick();
      bus.CLR_RESULTS = 0;
      check("clr_done", 32'(bus.CYCLE_DONE), 32'd1);
      check("clr_fail", 32'(bus.CYCLE_FAIL), 32'd1);
      check("clr_fcnt", 32'(bus.FAIL_COUNT), 32'd0);
      check("clr_vcnt", 32'(bus.VEC_COUNT), 32'd0);
      check("clr_stky", 32'(bus.FAIL_STICKY), 32'd0);

      // EN drop at counter 4 abandons the cycle
      repeat (3) tick();
      bus.EN = 0;
      done_seen = 0;
      repeat (12) tick();
      check("endrop_dones", 32'(done_seen), 32'd0);
      check("endrop_vcnt",  32'(bus.VEC_COUNT), 32'd0);
      bus.EN = 1;
      repeat (10) tick();
      check("restart_done", 32'(bus.CYCLE_DONE), 32'd1);
      check("restart_vcnt", 32'(bus.VEC_COUNT), 32'd1);

      // second failure, then reset at counter 7
      repeat (10) tick();
      check("pre_rst_fcnt", 32'(bus.FAIL_COUNT), 32'd2);
      repeat (6) tick();
      RST = 1;
      tick();
      RST = 0;
      check("rst_mid_done", 32'(bus.CYCLE_DONE), 32'd0);
      check("rst_mid_fcnt", 32'(bus.FAIL_COUNT), 32'd0);
      check("rst_mid_vcnt", 32'(bus.VEC_COUNT), 32'd0);
      check("rst_mid_stky", 32'(bus.FAIL_STICKY), 32'd0);
      done_seen = 0;
      repeat (10) tick();
      check("post_rst_dones", 32'(done_seen), 32'd1);
      check("post_rst_done",  32'(bus.CYCLE_DONE), 32'd1);
      check("post_rst_vcnt",  32'(bus.VEC_COUNT), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ff_compare.md
# ff_compare

Response-side counterpart to the force-format pin driver: samples a DUT output pin once per tester cycle, compares it against an expected value under a mask, and accumulates pass/fail results. It uses the same cycle-length/edge-position timing scheme as the drive side, so one tester-cycle definition governs both stimulus and capture. Strobe is either a single edge or a window. Results go to the tester controller as per-cycle pulses plus sticky counters.

## Interface
- CW, 8, width of cycle counter, CYCLE_LENGTH and strobe positions
- FCW, 16, width of FAIL_COUNT
- VCW, 16, width of VEC_COUNT and FIRST_FAIL_VEC
- CLK  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- EN  in  1  run enable; low holds cycle counter at 1 and abandons the current cycle
- CYCLE_LENGTH  in  CW  CLK periods per tester cycle; legal 1..2^CW-1; 0 treated as 1
- STROBE_START  in  CW  counter value of the edge strobe / first window sample
- STROBE_END  in  CW  counter value of the last window sample (window mode only)
- CMP_MODE  in  1  0 = edge strobe, 1 = window strobe
- PIN  in  1  asynchronous DUT response pin
- EXP  in  1  expected pin value for the cycle
- MASK  in  1  1 = don't-care; the cycle never fails
- CLR_RESULTS  in  1  synchronous clear of result accumulators
- CYCLE_DONE  out  1  one-CLK pulse when a tester cycle completes
- CYCLE_FAIL  out  1  valid with CYCLE_DONE; 1 = cycle failed
- FAIL_STICKY  out  1  set on first failure; held until RST/CLR_RESULTS
- FAIL_COUNT  out  FCW  failing cycles; saturates at all-ones
- VEC_COUNT  out  VCW  completed cycles; saturates at all-ones
- FIRST_FAIL_VEC  out  VCW  0-based index of the first failing cycle

## Operation
- PIN passes through a 2-flop synchronizer (pin_s). A compare at counter value k sees PIN as it was 2 CLKs earlier. Software offsets strobe edges by 2.
- Cycle counter: reset to 1 on RST, !EN, or counter==CYCLE_LENGTH; otherwise increments by 1 each CLK. A CYCLE_LENGTH of 0 makes counter==1 the wrap point.
- At counter==1, EXP and MASK are latched into exp_l/mask_l and the mismatch accumulator is cleared. The latch and clear happen in the same CLK; the clear does not drop a sample taken at counter==1.
- Edge mode: mismatch is set iff counter==STROBE_START and pin_s != exp_l.
- Window mode: mismatch is set at every counter value in [STROBE_START, STROBE_END] inclusive where pin_s != exp_l.
  - If STROBE_END < STROBE_START, only STROBE_START is sampled.
- If STROBE_START > CYCLE_LENGTH, no sample is taken and the cycle passes.
- At counter==CYCLE_LENGTH, the mismatch from this CLK is included, and on the next edge:
  - CYCLE_DONE=1 and CYCLE_FAIL = mismatch & !mask_l.
  - VEC_COUNT increments.
  - If failing: FAIL_COUNT increments; if FAIL_STICKY was 0, FIRST_FAIL_VEC ← old VEC_COUNT and FAIL_STICKY ← 1.
- CLR_RESULTS zeroes FAIL_STICKY, FAIL_COUNT, VEC_COUNT and FIRST_FAIL_VEC. It does not disturb the cycle counter, the latches, or the current cycle's mismatch.
- CLR_RESULTS on the same edge as CYCLE_DONE: the clear wins and accumulators go to 0. CYCLE_DONE/CYCLE_FAIL still pulse with the true result.
- EN low mid-cycle: no CYCLE_DONE for the partial cycle, mismatch cleared, accumulators unchanged. Restart begins a fresh cycle at counter 1.

## Timing
- Reset values: every output 0; cycle counter 1; synchronizer flops, exp_l, mask_l, mismatch all 0.
- CYCLE_DONE rises on the edge where the counter returns to 1. With EN held high, it repeats every CYCLE_LENGTH CLKs.
- Accumulator outputs update on the same edge as CYCLE_DONE.
- Pin-to-result latency: 2 CLKs (synchronizer) plus the remainder of the tester cycle.
- RST mid-cycle: on the next edge, all state returns to reset values and no CYCLE_DONE is produced.

## Test plan
- Edge pass/fail: CYCLE_LENGTH=10, STROBE_START=5, CMP_MODE=0, EXP=1, PIN=1 for 3 cycles, then PIN=0 for 1 cycle. Required: four CYCLE_DONE pulses 10 CLKs apart; CYCLE_FAIL only on the 4th; FAIL_COUNT=1, FIRST_FAIL_VEC=3, VEC_COUNT=4, FAIL_STICKY=1.
- Window glitch: CYCLE_LENGTH=20, window 6..12, EXP=0, single-CLK PIN=1 pulse so that pin_s=1 at counter 9. Required: CYCLE_FAIL=1. The same pulse landing at pin_s counter 14 gives CYCLE_FAIL=0.
- Mask: failing edge compare with MASK=1. Required: CYCLE_FAIL=0, VEC_COUNT increments, FAIL_COUNT unchanged.
- Boundaries:
  - STROBE_START=15 with CYCLE_LENGTH=10: never fails.
  - CYCLE_LENGTH=0: CYCLE_DONE every CLK.
  - FAIL_COUNT preloaded near saturation (FCW=4): holds at 15.
- Clear collision and EN drop: assert CLR_RESULTS on the CYCLE_DONE edge of a failing cycle. Required: CYCLE_FAIL=1 pulses, FAIL_COUNT=0 afterward. Then drop EN at counter 4. Required: no CYCLE_DONE, VEC_COUNT unchanged.
- Reset mid-cycle: RST at counter 7 after 2 failures. Required: all outputs 0 next edge, counter 1, no CYCLE_DONE.
